uart_frame_rx: RTL and testbench
================================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter CLK_BAUD_RATIO, default 25, meaning clock cycles per UART bit (legal range 4 or more).
REQ-002 SHALL have parameter FRAME_SIZE, default 8, meaning data bits per UART frame.
REQ-003 SHALL have parameter FRAMES, default 3, meaning frames assembled into one output word.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port receive_in, input, 1 bit: arm request, sampled only in IDLE.
REQ-007 SHALL have port rx_in, input, 1 bit: asynchronous UART line, idle high.
REQ-008 SHALL have port data_out, output, FRAMES*FRAME_SIZE bits: the assembled word.
REQ-009 SHALL have port new_data_out, output, 1 bit: one-cycle pulse when data_out is valid.
REQ-010 SHALL have port frame_error_out, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port busy_out, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL pass rx_in through a 2-flop synchroniser, both flops resetting to 1; all line decisions use the synchronised value rxs.
REQ-013 SHALL implement states IDLE, ARMED, START, DATA and STOP.
REQ-014 SHALL go IDLE to ARMED on a clock where receive_in=1; receive_in is ignored in every other state, and a pulse or a level are equivalent.
REQ-015 SHALL go ARMED to START on the first clock with rxs=0, and clear the baud counter.
REQ-016 In START, SHALL count (CLK_BAUD_RATIO-1)/2 cycles (integer division; 12 at the default), then sample rxs: 0 goes to DATA, 1 is a glitch and returns to ARMED with no output pulse.
REQ-017 In DATA, SHALL sample rxs every CLK_BAUD_RATIO cycles, FRAME_SIZE samples, first-received bit into the byte LSB.
REQ-018 In STOP, SHALL sample rxs CLK_BAUD_RATIO cycles after the last data sample.
REQ-019 On a stop sample of 1, SHALL store the byte into word slice [k*FRAME_SIZE +: FRAME_SIZE], where k is the frame index 0..FRAMES-1 (first frame in the LSBs), then increment k.
REQ-020 If k reaches FRAMES after that store, SHALL on the next clock:
  - drive data_out with the full word;
  - pulse new_data_out for exactly 1 cycle;
  - clear k;
  - go to IDLE.
  Otherwise the next state SHALL be ARMED, waiting for the next start bit.
REQ-021 On a stop sample of 0, SHALL on the next clock:
  - pulse frame_error_out for 1 cycle;
  - discard the partial word and clear k;
  - keep data_out unchanged;
  - go to ARMED.
REQ-022 SHALL change data_out only in the completion cycle, and hold it until the next completion.
REQ-023 SHALL use a baud counter of $clog2(CLK_BAUD_RATIO) bits, wrapping to 0 at each sample point; k SHALL be $clog2(FRAMES+1) bits.
REQ-024 SHALL report latency of 1 clock from the final stop-bit sample to new_data_out.
REQ-025 SHALL never assert new_data_out and frame_error_out in the same cycle.
REQ-026 SHALL re-arm only through a fresh receive_in after completion; a line held low while in IDLE SHALL be ignored.

Reset
REQ-027 While rst_in=0 SHALL asynchronously set:
  - state to IDLE;
  - k=0 and the baud counter to 0;
  - data_out=0;
  - new_data_out=0, frame_error_out=0, busy_out=0;
  - both synchroniser flops to 1.
REQ-028 On a reset mid-frame, SHALL discard partial data with no output pulse; after release, normal operation resumes from IDLE.

Verification
REQ-029 With defaults, pulse receive_in, then send 0x5A, 0x3C, 0x01 (8N1, 25 clk/bit) -> data_out=0x013C5A, exactly one new_data_out pulse 1 clk after the third stop sample, then busy_out=0.
REQ-030 While ARMED, drive rx low for 5 clocks and then high -> no pulses, state returns to ARMED; then send 3 valid bytes -> a correct word is produced.
REQ-031 Send 0xFF with the stop bit forced to 0 on frame 2 -> one frame_error_out pulse, no new_data_out, data_out unchanged; then send 3 good bytes 0x11, 0x22, 0x33 -> data_out=0x332211.
REQ-032 With receive_in=0 throughout, send 3 bytes -> busy_out stays 0 and no pulses occur.
REQ-033 Assert rst_in low mid-way through bit 4 of frame 1 -> all outputs 0 immediately; release, re-arm, send 0xAA, 0xBB, 0xCC -> data_out=0xCCBBAA.
REQ-034 Run with CLK_BAUD_RATIO=4, FRAMES=1, and send 0x81 with receive_in asserted again 1 clk after new_data_out -> data_out=0x000081 (width 8: 0x81); the second word is received correctly back-to-back.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: UART receiver that collects FRAMES consecutive frames into one
// wide word, with glitch rejection on the start bit and stop-bit error reporting.
//
// state | meaning
// IDLE  | waiting for an arm request on receive_in
// ARMED | armed, waiting for the synchronised line to fall
// START | counting to mid start bit, then confirming it is still low
// DATA  | sampling FRAME_SIZE data bits, one per baud period, LSB first
// STOP  | sampling the stop bit, then one cycle to store/complete/report
module uart_frame_rx #(
  parameter int CLK_BAUD_RATIO = 25,
  parameter int FRAME_SIZE     = 8,
  parameter int FRAMES         = 3
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         receive_in,
  input  logic                         rx_in,
  output logic [FRAMES*FRAME_SIZE-1:0] data_out,
  output logic                         new_data_out,
  output logic                         frame_error_out,
  output logic                         busy_out
);

  localparam int CW = $clog2(CLK_BAUD_RATIO);
  localparam int KW = $clog2(FRAMES + 1);
  localparam int BW = $clog2(FRAME_SIZE + 1);
  localparam int WW = FRAMES * FRAME_SIZE;

  localparam logic [CW-1:0] HALF_LAST = CW'((CLK_BAUD_RATIO - 1) / 2 - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_BAUD_RATIO - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_SIZE - 1);
  localparam logic [KW-1:0] K_FULL    = KW'(FRAMES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rxs_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_SIZE-1:0] shift_q, shift_d;
  logic [WW-1:0]         word_q, word_d;
  logic [WW-1:0]         data_q, data_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  done_q, done_d;
  logic                  stop_ok_q, stop_ok_d;
  logic                  new_q, new_d;
  logic                  err_q, err_d;

  logic half_tc, baud_tc, last_bit, word_full;

  assign half_tc   = (cnt_q == HALF_LAST);
  assign baud_tc   = (cnt_q == BAUD_LAST);
  assign last_bit  = (bit_q == BIT_LAST);
  assign word_full = (k_q == K_FULL);

  // Two-flop synchroniser; both flops reset to the idle-high line level.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx_in;
      rxs_q     <= rx_meta_q;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (receive_in) state_d = S_ARMED;
      S_ARMED: if (!rxs_q) state_d = S_START;
      S_START: if (half_tc) state_d = rxs_q ? S_ARMED : S_DATA;
      S_DATA:  if (baud_tc && last_bit) state_d = S_STOP;
      S_STOP:  if (done_q) state_d = (stop_ok_q && word_full) ? S_IDLE : S_ARMED;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; the stop sample is stored first, and the
  // completion or error decision is taken on the following cycle.
  always_comb begin
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    word_d    = word_q;
    k_d       = k_q;
    done_d    = 1'b0;
    stop_ok_d = stop_ok_q;
    data_d    = data_q;
    new_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE, S_ARMED: cnt_d = '0;
      S_START: begin
        bit_d = '0;
        if (half_tc) cnt_d = '0;
      end
      S_DATA: begin
        if (baud_tc) begin
          cnt_d   = '0;
          bit_d   = bit_q + BW'(1);
          shift_d = {rxs_q, shift_q[FRAME_SIZE-1:1]};
        end
      end
      S_STOP: begin
        if (done_q) begin
          if (!stop_ok_q) begin
            err_d = 1'b1;
            k_d   = '0;
          end else if (word_full) begin
            data_d = word_q;
            new_d  = 1'b1;
            k_d    = '0;
          end
        end else if (baud_tc) begin
          cnt_d     = '0;
          done_d    = 1'b1;
          stop_ok_d = rxs_q;
          if (rxs_q) begin
            for (int i = 0; i < FRAMES; i++) begin
              if (k_q == KW'(i)) word_d[i*FRAME_SIZE +: FRAME_SIZE] = shift_q;
            end
            k_d = k_q + KW'(1);
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      stop_ok_q <= 1'b0;
      data_q    <= '0;
      new_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      k_q       <= k_d;
      done_q    <= done_d;
      stop_ok_q <= stop_ok_d;
      data_q    <= data_d;
      new_q     <= new_d;
      err_q     <= err_d;
    end
  end

  assign data_out        = data_q;
  assign new_data_out    = new_q;
  assign frame_error_out = err_q;
  assign busy_out        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: default instance checked every cycle against a
// timestamp model of frame arrival; a small fast instance checked back-to-back.
module tb_uart_frame_rx;

  localparam int R  = 25;
  localparam int FS = 8;
  localparam int FR = 3;
  localparam int H  = (R - 1) / 2;
  localparam int R2 = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        receive_in = 1'b0;
  logic        rx_in = 1'b1;
  logic [23:0] data_out;
  logic        new_data_out, frame_error_out, busy_out;

  logic        receive2 = 1'b0;
  logic        rx2 = 1'b1;
  logic [7:0]  data2;
  logic        new2, err2, busy2;

  always #5 clk_in = ~clk_in;

  uart_frame_rx #(.CLK_BAUD_RATIO(R), .FRAME_SIZE(FS), .FRAMES(FR)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .receive_in(receive_in), .rx_in(rx_in),
    .data_out(data_out), .new_data_out(new_data_out),
    .frame_error_out(frame_error_out), .busy_out(busy_out));

  uart_frame_rx #(.CLK_BAUD_RATIO(R2), .FRAME_SIZE(8), .FRAMES(1)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .receive_in(receive2), .rx_in(rx2),
    .data_out(data2), .new_data_out(new2),
    .frame_error_out(err2), .busy_out(busy2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Model: expected output changes keyed by the posedge count after which they show.
  typedef struct {
    int          cyc;
    logic [23:0] val;
  } chg_t;

  chg_t        exp_data_chg[$];
  chg_t        exp_busy_chg[$];
  int          exp_new_cyc[$];
  int          exp_err_cyc[$];
  logic [23:0] exp_data = '0;
  logic        exp_busy = 1'b0;
  bit          en_new, en_err;
  bit          chk_en = 1'b0;

  bit          m_active = 1'b0;
  int          m_ready = 0;
  int          m_idle_from = 0;
  int          m_k = 0;
  logic [23:0] m_word = '0;

  // A frame whose start bit is first seen on rx_in at edge e0 is detected at
  // the later of e0+2 (synchroniser) and one edge after the receiver is armed;
  // the stop bit is then sampled H + 9 baud periods later, and results show one
  // edge after that.
  task automatic model_frame(input int e0, input logic [7:0] b, input logic stop_b);
    int s, e;
    chg_t c;
    if (!m_active) return;
    s = (m_ready + 1 > e0 + 2) ? m_ready + 1 : e0 + 2;
    e = s + H + (FS + 1) * R;
    if (stop_b) begin
      m_word[m_k*FS +: FS] = b;
      m_k++;
      if (m_k == FR) begin
        exp_new_cyc.push_back(e + 1);
        c.cyc = e + 1; c.val = m_word; exp_data_chg.push_back(c);
        c.val = 24'd0; exp_busy_chg.push_back(c);
        m_active = 1'b0;
        m_idle_from = e + 1;
        m_k = 0;
      end else begin
        m_ready = e + 1;
      end
    end else begin
      exp_err_cyc.push_back(e + 1);
      m_k = 0;
      m_ready = e + 1;
    end
  endtask

  // Compare DUT outputs to the model on every falling edge.
  always @(negedge clk_in) begin
    if (chk_en) begin
      while (exp_data_chg.size() > 0 && exp_data_chg[0].cyc <= cyc) begin
        exp_data = exp_data_chg[0].val;
        exp_data_chg.delete(0);
      end
      while (exp_busy_chg.size() > 0 && exp_busy_chg[0].cyc <= cyc) begin
        exp_busy = exp_busy_chg[0].val[0];
        exp_busy_chg.delete(0);
      end
      while (exp_new_cyc.size() > 0 && exp_new_cyc[0] < cyc) exp_new_cyc.delete(0);
      while (exp_err_cyc.size() > 0 && exp_err_cyc[0] < cyc) exp_err_cyc.delete(0);
      en_new = (exp_new_cyc.size() > 0 && exp_new_cyc[0] == cyc);
      en_err = (exp_err_cyc.size() > 0 && exp_err_cyc[0] == cyc);
      check("data_out", 32'(data_out), 32'(exp_data));
      check("new_data_out", 32'(new_data_out), 32'(en_new));
      check("frame_error_out", 32'(frame_error_out), 32'(en_err));
      check("busy_out", 32'(busy_out), 32'(exp_busy));
    end
  end

  int new_cnt = 0, err_cnt = 0, last_new_cyc = -1, err2_cnt = 0;
  int p2_q[$];
  logic [7:0] d2_q[$];

  // Pulse bookkeeping for the literal checks.
  always @(negedge clk_in) begin
    if (new_data_out) begin new_cnt++; last_new_cyc = cyc; end
    if (frame_error_out) err_cnt++;
    if (new2) begin p2_q.push_back(cyc); d2_q.push_back(data2); end
    if (err2) err2_cnt++;
  end

  int last_e0 = 0;

  // All stimulus tasks start and end on a falling edge.
  task automatic arm();
    int r;
    chg_t c;
    receive_in = 1'b1;
    r = cyc + 1;
    if (!m_active && r >= m_idle_from + 1) begin
      m_active = 1'b1;
      m_ready = r;
      c.cyc = r; c.val = 24'd1; exp_busy_chg.push_back(c);
    end
    @(negedge clk_in);
    receive_in = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_b, input int cut);
    logic [9:0] bits;
    int n, e0;
    bits = {stop_b, b, 1'b0};
    e0 = cyc + 1;
    last_e0 = e0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      for (int j = 0; j < R; j++) begin
        if (n == cut) return;
        if (i == 1 && j == 0) model_frame(e0, b, stop_b);
        @(negedge clk_in);
        n++;
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int f = 0; f < 3; f++) send_frame(w[f*8 +: 8], 1'b1, 10 * R);
  endtask

  task automatic glitch(input int low_cycles);
    int e0, s;
    e0 = cyc + 1;
    rx_in = 1'b0;
    repeat (low_cycles) @(negedge clk_in);
    rx_in = 1'b1;
    if (m_active) begin
      s = (m_ready + 1 > e0 + 2) ? m_ready + 1 : e0 + 2;
      m_ready = s + H;
    end
  endtask

  task automatic do_reset();
    #2;
    rst_in = 1'b0;
    rx_in = 1'b1;
    exp_data_chg.delete(); exp_busy_chg.delete();
    exp_new_cyc.delete(); exp_err_cyc.delete();
    exp_data = '0; exp_busy = 1'b0;
    m_active = 1'b0; m_k = 0; m_word = '0; m_idle_from = 0;
    #1;
    check("reset data_out", 32'(data_out), 32'h0);
    check("reset new_data_out", 32'(new_data_out), 32'h0);
    check("reset frame_error_out", 32'(frame_error_out), 32'h0);
    check("reset busy_out", 32'(busy_out), 32'h0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  task automatic send2(input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx2 = bits[i];
      repeat (R2) @(negedge clk_in);
    end
  endtask

  int nc0, ec0, e0a, w;

  initial begin
    repeat (3) @(negedge clk_in);
    check("por data_out", 32'(data_out), 32'h0);
    check("por busy_out", 32'(busy_out), 32'h0);
    check("por new_data_out", 32'(new_data_out), 32'h0);
    rst_in = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk_in);

    // Basic three-frame word.
    nc0 = new_cnt;
    arm();
    repeat (5) @(negedge clk_in);
    send_word(24'h013C5A);
    repeat (5) @(negedge clk_in);
    check("word 013C5A", 32'(data_out), 32'h013C5A);
    check("one pulse", 32'(new_cnt - nc0), 32'd1);
    check("pulse latency", 32'(last_new_cyc), 32'(last_e0 + 240));
    check("idle after word", 32'(busy_out), 32'h0);

    // Start-bit glitch, then a good word.
    nc0 = new_cnt; ec0 = err_cnt;
    arm();
    repeat (5) @(negedge clk_in);
    glitch(5);
    repeat (40) @(negedge clk_in);
    check("glitch stays armed", 32'(busy_out), 32'h1);
    check("glitch no pulses", 32'(new_cnt - nc0 + err_cnt - ec0), 32'd0);
    send_word(24'hC3B2A1);
    repeat (5) @(negedge clk_in);
    check("word after glitch", 32'(data_out), 32'hC3B2A1);

    // Bad stop bit on frame 2 discards the partial word.
    nc0 = new_cnt; ec0 = err_cnt;
    arm();
    repeat (5) @(negedge clk_in);
    send_frame(8'hFF, 1'b1, 10 * R);
    send_frame(8'hFF, 1'b0, 10 * R);
    repeat (20) @(negedge clk_in);
    check("one frame error", 32'(err_cnt - ec0), 32'd1);
    check("no word on error", 32'(new_cnt - nc0), 32'd0);
    check("data held on error", 32'(data_out), 32'hC3B2A1);
    send_word(24'h332211);
    repeat (5) @(negedge clk_in);
    check("word after error", 32'(data_out), 32'h332211);

    // Not armed: traffic is ignored.
    nc0 = new_cnt; ec0 = err_cnt;
    send_word(24'h665544);
    repeat (5) @(negedge clk_in);
    check("unarmed no pulses", 32'(new_cnt - nc0 + err_cnt - ec0), 32'd0);
    check("unarmed data held", 32'(data_out), 32'h332211);

    // Reset mid-frame, then recover.
    nc0 = new_cnt;
    arm();
    repeat (5) @(negedge clk_in);
    send_frame(8'hAA, 1'b1, R + 4 * R + 12);
    do_reset();
    repeat (3) @(negedge clk_in);
    arm();
    repeat (5) @(negedge clk_in);
    send_word(24'hCCBBAA);
    repeat (5) @(negedge clk_in);
    check("word after reset", 32'(data_out), 32'hCCBBAA);
    check("one pulse after reset", 32'(new_cnt - nc0), 32'd1);

    // Fast instance: single-frame words back to back, re-armed after the pulse.
    receive2 = 1'b1;
    @(negedge clk_in);
    receive2 = 1'b0;
    repeat (3) @(negedge clk_in);
    e0a = cyc + 1;
    fork
      begin
        send2(8'h81);
        send2(8'h7E);
      end
      begin
        w = 0;
        while (!new2 && w < 200) begin @(negedge clk_in); w++; end
        if (new2) begin
          @(negedge clk_in);
          receive2 = 1'b1;
          @(negedge clk_in);
          receive2 = 1'b0;
        end
      end
    join
    repeat (10) @(negedge clk_in);
    check("b2b pulse count", 32'(p2_q.size()), 32'd2);
    if (p2_q.size() == 2) begin
      check("b2b first cycle", 32'(p2_q[0]), 32'(e0a + 40));
      check("b2b first data", 32'(d2_q[0]), 32'h81);
      check("b2b second cycle", 32'(p2_q[1]), 32'(e0a + 81));
      check("b2b second data", 32'(d2_q[1]), 32'h7E);
    end
    check("b2b no errors", 32'(err2_cnt), 32'd0);
    check("b2b idle", 32'(busy2), 32'h0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
